seg7_scan_driver: RTL and testbench

//   Display-side consumer of the stopwatch Counter's BCD time reading. It drives the

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_driver.sv | 89 ++++++++
 tb/tb_seg7_scan_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants: active-low seven-segment patterns {g,f,e,d,c,b,a}
// and the all-off anode/segment values.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decode; non-decimal nibbles show a dash.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display: frame-latched BCD value,
// right-to-left scan, per-slot anti-ghosting guard, leading-zero blanking and decimal points.
module seg7_scan_driver
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned DIGIT_HZ     = 4000,
  parameter int unsigned GUARD_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        init_regs,
  input  logic [15:0] disp_value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned SLOT_CYCLES = CLK_FREQ / DIGIT_HZ;
  localparam int unsigned CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  if (GUARD_CYCLES >= SLOT_CYCLES) begin : g_guard_check
    $error("GUARD_CYCLES must be smaller than CLK_FREQ/DIGIT_HZ");
  end

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [15:0]      frame_val_q, frame_now;
  logic             frame_start, slot_last, in_guard, blanked;
  logic [3:0]       upper_zero, digit_nib, an_d;
  logic [6:0]       seg_dec, seg_d;
  logic             dp_d;

  assign frame_start = (slot_cnt_q == '0) && (digit_idx_q == 2'd0);
  assign slot_last   = (slot_cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign in_guard    = int'(slot_cnt_q) < int'(GUARD_CYCLES);

  // The latching cycle already displays the freshly sampled word.
  assign frame_now = frame_start ? disp_value : frame_val_q;
  assign digit_nib = 4'(frame_now >> {digit_idx_q, 2'b00});

  // upper_zero[i]: digit i and every digit above it are zero; digit 0 is never blanked.
  assign upper_zero[3] = (frame_now[15:12] == 4'd0);
  assign upper_zero[2] = upper_zero[3] && (frame_now[11:8] == 4'd0);
  assign upper_zero[1] = upper_zero[2] && (frame_now[7:4] == 4'd0);
  assign upper_zero[0] = 1'b0;
  assign blanked       = blank_lz && upper_zero[digit_idx_q];

  bcd_to_seg7 u_decode (
    .nibble (digit_nib),
    .seg    (seg_dec)
  );

  always_comb begin
    slot_cnt_d  = slot_last ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = slot_last ? digit_idx_q + 2'd1 : digit_idx_q;
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!in_guard && !blanked) begin
      an_d  = ~(4'b0001 << digit_idx_q);
      seg_d = seg_dec;
      dp_d  = ~dp_mask[digit_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (init_regs) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      frame_val_q <= 16'h0000;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      frame_val_q <= frame_now;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random traffic,
// compared every cycle against a timeline model of the scan.
module tb_seg7_scan_driver;

  localparam int unsigned CF   = 1000;
  localparam int unsigned DH   = 100;
  localparam int unsigned GC   = 2;
  localparam int unsigned SLOT = CF / DH;

  logic        clk = 1'b0;
  logic        init_regs;
  logic [15:0] disp_value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: cycles since reset release and the word shown in the current frame.
  int unsigned m_n = 0;
  logic [15:0] m_frame = 16'h0000;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_FREQ     (CF),
    .DIGIT_HZ     (DH),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .init_regs  (init_regs),
    .disp_value (disp_value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, m_n);
    end
  endtask

  // One clock: evaluate the model on the inputs present at the edge, then compare.
  task automatic tick();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  one_hot;
    logic [3:0]  nib;
    int unsigned c;
    int unsigned d;
    @(posedge clk);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (init_regs) begin
      m_n = 0;
    end else begin
      c = m_n % SLOT;
      d = (m_n / SLOT) % 4;
      if (m_n % (4 * SLOT) == 0) m_frame = disp_value;
      nib = 4'(m_frame >> (4 * d));
      if (c >= GC && !(blank_lz && d != 0 && (m_frame >> (4 * d)) == 0)) begin
        one_hot = 4'b0001 << d;
        e_an    = ~one_hot;
        e_seg   = seg_tab[nib];
        e_dp    = ~dp_mask[d];
      end
      m_n++;
    end
    #1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) tick();
  endtask

  task automatic run_until_phase(input int unsigned phase);
    for (int i = 0; i < 200; i++) begin
      if (m_n % (4 * SLOT) == phase) return;
      tick();
    end
    check("phase_timeout", 16'(m_n % (4 * SLOT)), 16'(phase));
  endtask

  initial begin
    int unsigned first_lit;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                7'b0111111};
    init_regs  = 1'b1;
    disp_value = 16'h1234;
    dp_mask    = 4'b0000;
    blank_lz   = 1'b0;
    run(3);

    // Release and measure latency to the first lit anode.
    init_regs = 1'b0;
    first_lit = 99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (an !== 4'hF) begin
        first_lit = k;
        break;
      end
    end
    check("first_lit", 16'(first_lit), 16'(GC + 1));
    run(40);

    disp_value = 16'h0102;
    run(80);

    blank_lz   = 1'b1;
    disp_value = 16'h0005;
    run(80);
    disp_value = 16'h0000;
    run(80);
    disp_value = 16'h0100;
    run(80);

    // Mid-frame change: held back until the next frame boundary.
    blank_lz   = 1'b0;
    disp_value = 16'h0012;
    run_until_phase(0);
    run(1);
    run_until_phase(15);
    disp_value = 16'h0034;
    run(70);

    disp_value = 16'h00A7;
    run(80);
    dp_mask = 4'b0100;
    run(80);

    // Reset pulse during the digit-2 lit phase.
    run_until_phase(25);
    init_regs = 1'b1;
    tick();
    init_regs  = 1'b0;
    disp_value = 16'h5678;
    run(80);

    for (int it = 0; it < 40; it++) begin
      disp_value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) disp_value = disp_value & 16'h00FF;
      dp_mask  = 4'($urandom);
      blank_lz = 1'($urandom);
      run($urandom_range(5, 60));
      if ($urandom_range(0, 7) == 0) begin
        init_regs = 1'b1;
        run($urandom_range(1, 3));
        init_regs = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
